shift_unit: RTL and testbench



---
 rtl/shift_unit_if.sv | 23 ++
 rtl/shift_unit.sv | 83 ++++++++
 tb/tb_shift_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_if.sv
// Request/response bundle between the execute-stage control and the
// multi-cycle shifter.
interface shift_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] shamt;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, shamt, data,
        input  busy, done, result
    );

    modport slave (
        input  start, op, shamt, data,
        output busy, done, result
    );
endinterface

// File: rtl/shift_unit.sv
// Bit-serial shifter: one bit position per clock, with a start/busy/done
// handshake. The result is the working register itself.
module shift_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    shift_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_work;
    logic [4:0]       r_count;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] w_shifted;
    logic             w_unused_shamtHigh;

    // Only the low five shamt bits count; the upper bits are deliberately dropped.
    assign w_unused_shamtHigh = ^bus.shamt[WIDTH-1:5];

    always_comb begin
        w_shifted = r_work;
        case (r_op)
            OP_SLL:  w_shifted = {r_work[WIDTH-2:0], 1'b0};
            OP_SRL:  w_shifted = {1'b0, r_work[WIDTH-1:1]};
            OP_SRA:  w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            OP_ROTR: w_shifted = {r_work[0], r_work[WIDTH-1:1]};
            default: w_shifted = r_work;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_nextState = S_SHIFT;
            S_SHIFT: if (r_count == 5'd0) w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_count <= 5'd0;
            r_op    <= OP_SLL;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_work  <= bus.data;
                        r_op    <= bus.op;
                        r_count <= bus.shamt[4:0];
                    end
                end
                S_SHIFT: begin
                    if (r_count != 5'd0) begin
                        r_work  <= w_shifted;
                        r_count <= r_count - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_work;
endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed vector table, hand-written
// handshake/reset sequences and randomized operations against a reference model.
module tb_shift_unit;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] shamt;
        logic [31:0] expResult;
        int          expLatency;
    } vector_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    shift_unit_if #(.WIDTH(32)) bus ();

    shift_unit #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model works from the shift definitions directly, not bit-by-bit.
    function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] d,
                                             input logic [31:0] sh);
        int                 n;
        logic signed [31:0] s;
        n = int'(sh % 32);
        s = d;
        case (op)
            2'b00:   return d << n;
            2'b01:   return d >> n;
            2'b10:   return s >>> n;
            default: return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issues one operation, waits (bounded) for done; lat = cycles from acceptance to done.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] d,
                                 input logic [31:0] sh, output logic [31:0] res,
                                 output int lat);
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.data  = d;
        bus.shamt = sh;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.data  = $urandom;
        bus.shamt = $urandom;
        lat  = -1;
        res  = '0;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) checkOutput("busy_after_accept", 32'(bus.busy), 32'd1);
            if (bus.done) begin
                seen = 1'b1;
                lat  = c;
                res  = bus.result;
            end
        end
        if (seen) begin
            @(negedge clk);
            checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
            checkOutput("busy_after_done", 32'(bus.busy), 32'd0);
            checkOutput("result_holds", bus.result, res);
        end
    endtask

    vector_t table_v[$];

    initial begin
        logic [31:0] res;
        int          lat;
        int          donePulses;
        logic [1:0]  rop;
        logic [31:0] rdata;
        logic [31:0] rsh;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.data    = '0;
        bus.shamt   = '0;

        table_v.push_back('{2'b00, 32'h0000_00F0, 32'd4,          32'h0000_0F00, 6});
        table_v.push_back('{2'b01, 32'h0000_00F0, 32'd4,          32'h0000_000F, 6});
        table_v.push_back('{2'b10, 32'h8000_0000, 32'h0000_001F,  32'hFFFF_FFFF, 33});
        table_v.push_back('{2'b10, 32'h8000_0000, 32'h0000_0021,  32'hC000_0000, 3});
        table_v.push_back('{2'b11, 32'h1234_5678, 32'd8,          32'h7812_3456, 10});
        table_v.push_back('{2'b00, 32'h1234_5678, 32'd0,          32'h1234_5678, 2});
        table_v.push_back('{2'b01, 32'h1234_5678, 32'd0,          32'h1234_5678, 2});
        table_v.push_back('{2'b10, 32'h1234_5678, 32'd0,          32'h1234_5678, 2});
        table_v.push_back('{2'b11, 32'h1234_5678, 32'd0,          32'h1234_5678, 2});
        table_v.push_back('{2'b00, 32'h1234_5678, 32'd32,         32'h1234_5678, 2});
        table_v.push_back('{2'b11, 32'h0000_0001, 32'd1,          32'h8000_0000, 3});
        table_v.push_back('{2'b10, 32'h4000_0000, 32'd3,          32'h0800_0000, 5});

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_result", bus.result, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < table_v.size(); i++) begin
            applyStimulus(table_v[i].op, table_v[i].data, table_v[i].shamt, res, lat);
            checkOutput($sformatf("table%0d_result", i), res, table_v[i].expResult);
            checkOutput($sformatf("table%0d_latency", i), 32'(lat), 32'(table_v[i].expLatency));
        end

        // Reset in the third busy cycle must abort with no done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.data  = 32'h8000_0001;
        bus.shamt = 32'd20;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midop_busy_before_reset", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midop_reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("midop_reset_done", 32'(bus.done), 32'd0);
        checkOutput("midop_reset_result", bus.result, 32'h0);
        donePulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) donePulses++;
        end
        checkOutput("midop_no_done", 32'(donePulses), 32'd0);

        // Start held high: busy-time starts are ignored, re-accept right after done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.data  = 32'h0000_0001;
        bus.shamt = 32'd3;
        @(posedge clk);
        #1;
        bus.data = 32'hFFFF_FFFF;
        lat = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.done) lat = c;
        end
        checkOutput("hold_first_latency", 32'(lat), 32'd5);
        checkOutput("hold_first_result", bus.result, 32'h0000_0008);
        @(negedge clk);
        checkOutput("hold_idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("hold_result_before_accept", bus.result, 32'h0000_0008);
        @(negedge clk);
        checkOutput("hold_second_accept_busy", 32'(bus.busy), 32'd1);
        lat = -1;
        for (int c = 2; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.done) lat = c;
        end
        bus.start = 1'b0;
        checkOutput("hold_second_latency", 32'(lat), 32'd5);
        checkOutput("hold_second_result", bus.result, 32'hFFFF_FFF8);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            rop   = 2'($urandom);
            rdata = $urandom;
            rsh   = (i % 4 == 0) ? $urandom : 32'($urandom_range(0, 40));
            applyStimulus(rop, rdata, rsh, res, lat);
            checkOutput($sformatf("rand%0d_result", i), res, refModel(rop, rdata, rsh));
            checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'(int'(rsh % 32) + 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
